// File: rtl/spc_pkg.sv
// Shared command codes, FSM encoding and phase limits for the
// photon-counting trigger/counter blocks.
package spc_pkg;

  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] CMD_START = 8'h01;

  // 3-flop edge detector downstream needs this many cycles per phase
  localparam int MIN_PHASE_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/dmd_trigger_gen_if.sv
// Command bundle from the SPI decoder into the DMD trigger generator.
interface dmd_trigger_gen_if #(
  parameter int PERIOD_W = 24,
  parameter int PULSE_W  = 16,
  parameter int CNT_W    = 16
);
  logic                CMD_VALID;
  logic [7:0]          CMD;
  logic [PERIOD_W-1:0] PERIOD;
  logic [PULSE_W-1:0]  PULSE_LEN;
  logic [CNT_W-1:0]    N_PATTERNS;

  modport master (
    output CMD_VALID, CMD,
    output PERIOD, PULSE_LEN, N_PATTERNS
  );

  modport slave (
    input CMD_VALID, CMD,
    input PERIOD, PULSE_LEN, N_PATTERNS
  );
endinterface

// File: rtl/dmd_trigger_gen_phase_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module phase_timer #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dmd_trigger_gen.sv
// DMD pattern-advance pulse train: N pulses of programmable
// period/high time, abortable by a stop command.
module dmd_trigger_gen
  import spc_pkg::*;
#(
  parameter int PERIOD_W  = 24,
  parameter int PULSE_W   = 16,
  parameter int CNT_W     = 16,
  parameter int MIN_PHASE = MIN_PHASE_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  dmd_trigger_gen_if.slave cmd,
  output logic             DMD_Signal,
  output logic [CNT_W-1:0] FRAME_IDX,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [PERIOD_W-1:0] MIN_P =
    PERIOD_W'(MIN_PHASE);
  localparam logic [PERIOD_W-1:0] MIN_2P =
    PERIOD_W'(2 * MIN_PHASE);
  localparam logic [PERIOD_W-1:0] ONE =
    PERIOD_W'(1);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] hi_q, hi_d;
  logic [PERIOD_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    frame_q, frame_d;
  logic                dmd_q, dmd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load;
  logic [PERIOD_W-1:0] tmr_val;
  logic                tmr_tc;

  logic                start, stop, more;
  logic [PERIOD_W-1:0] pl_ext, hi_m, per_c;
  logic [PERIOD_W-1:0] hi_c, lo_c;

  assign start = cmd.CMD_VALID &&
                 (cmd.CMD == CMD_START);
  assign stop  = cmd.CMD_VALID &&
                 (cmd.CMD == CMD_IDLE);

  // Clamp order matters: floor both phases, then
  // shrink high time so low keeps MIN_PHASE.
  assign pl_ext = PERIOD_W'(cmd.PULSE_LEN);
  assign hi_m   = (pl_ext < MIN_P) ? MIN_P : pl_ext;
  assign per_c  = (cmd.PERIOD < MIN_2P) ?
                  MIN_2P : cmd.PERIOD;
  assign hi_c   = (hi_m > per_c - MIN_P) ?
                  (per_c - MIN_P) : hi_m;
  assign lo_c   = per_c - hi_c;

  assign more = (n_q == '0) ||
                (frame_q < n_q - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    n_d      = n_q;
    frame_d  = frame_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = HIGH;
          hi_d     = hi_c;
          lo_d     = lo_c;
          n_d      = cmd.N_PATTERNS;
          frame_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = hi_c - ONE;
        end
      end
      HIGH: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tmr_tc) begin
          state_d  = LOW;
          tmr_load = 1'b1;
          tmr_val  = lo_q - ONE;
        end
      end
      LOW: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tmr_tc) begin
          if (more) begin
            state_d  = HIGH;
            frame_d  = frame_q + CNT_W'(1);
            tmr_load = 1'b1;
            tmr_val  = hi_q - ONE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dmd_d  = (state_d == HIGH);
    busy_d = (state_d == HIGH) ||
             (state_d == LOW);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      n_q     <= '0;
      frame_q <= '0;
      dmd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      n_q     <= n_d;
      frame_q <= frame_d;
      dmd_q   <= dmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  phase_timer #(
    .W (PERIOD_W)
  ) u_phase_timer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  assign DMD_Signal = dmd_q;
  assign FRAME_IDX  = frame_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule
